// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: FSM state encoding, the default
// memory timeout and the byte-lane indices used by the lane unit.
package lsu_pkg;

    localparam int TIMEOUT_CYC_DEF = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] LANE0 = 2'd0;  // bits [7:0]
    localparam logic [1:0] LANE1 = 2'd1;  // bits [15:8]
    localparam logic [1:0] LANE2 = 2'd2;  // bits [23:16]
    localparam logic [1:0] LANE3 = 2'd3;  // bits [31:24]

    // Memory is word-addressed on the bus; the byte offset never leaves the LSU.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/lane_unit.sv
// Byte-lane helper: extracts one zero-extended byte from a memory word and
// builds the read-modify-write word with that byte replaced.
module lane_unit
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [7:0]  wbyte,
    output logic [31:0] load_byte,
    output logic [31:0] merged
);

    // Select the lane for both the load path and the merge path.
    always_comb begin
        // NOTE: defaults before the case keep every output assigned on every
        // path, so no latch is inferred.
        load_byte = '0;
        merged    = word;
        case (lane)
            LANE0: begin load_byte = {24'b0, word[7:0]};   merged[7:0]   = wbyte; end
            LANE1: begin load_byte = {24'b0, word[15:8]};  merged[15:8]  = wbyte; end
            LANE2: begin load_byte = {24'b0, word[23:16]}; merged[23:16] = wbyte; end
            LANE3: begin load_byte = {24'b0, word[31:24]}; merged[31:24] = wbyte; end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller between a CPU request port and a word-wide memory.
// Byte stores are done as read-modify-write. A phase that waits TIMEOUT_CYC
// cycles without mem_ack ends the access with err=1 and rdata=0. Stores
// return rdata=0. The byte-access input is named byte_acc because "byte" is
// a reserved word.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        byte_acc,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int            CW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [1:0]    state;
    logic          we_q;
    logic          byte_q;
    logic [31:0]   addr_q;
    logic [31:0]   wword_q;   // store data; for byte stores becomes the merged word
    logic [CW-1:0] wait_cnt;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic [31:0]   load_byte;
    logic [31:0]   merged;

    // Lane logic works on the live read word so the merge is ready at ack.
    lane_unit u_lane (
        .word      (mem_rdata),
        .lane      (addr_q[1:0]),
        .wbyte     (wword_q[7:0]),
        .load_byte (load_byte),
        .merged    (merged)
    );

    // Outputs decode straight from state so reset drops mem_req immediately.
    always_comb begin
        done      = (state == ST_DONE);
        busy      = (state != ST_IDLE);
        mem_req   = (state == ST_RD) || (state == ST_WR);
        mem_we    = (state == ST_WR);
        mem_addr  = word_align(addr_q);
        mem_wdata = wword_q;
        rdata     = rdata_q;
        err       = err_q;
    end

    // Access sequencing, operand capture, wait counting and result latching.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every
        // register sees the pre-edge values of the others.
        if (!reset) begin
            state    <= ST_IDLE;
            we_q     <= 1'b0;
            byte_q   <= 1'b0;
            addr_q   <= '0;
            wword_q  <= '0;
            wait_cnt <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        we_q     <= we;
                        byte_q   <= byte_acc;
                        addr_q   <= addr;
                        wword_q  <= wdata;
                        wait_cnt <= '0;
                        state    <= (we && !byte_acc) ? ST_WR : ST_RD;
                    end
                end
                ST_RD: begin
                    if (mem_ack) begin
                        wait_cnt <= '0;
                        if (we_q) begin
                            wword_q <= merged;
                            state   <= ST_WR;
                        end else begin
                            rdata_q <= byte_q ? load_byte : mem_rdata;
                            err_q   <= 1'b0;
                            state   <= ST_DONE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == LAST) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_WR: begin
                    if (mem_ack) begin
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        state   <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == LAST) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl. The driver plans each access from the
// behavioural rules (phases, lane arithmetic, timeout) and queues the expected
// outputs per cycle; one compare process checks them on every falling edge.
module tb_lsu_ctrl;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we, byte_acc, mem_ack;
    logic [31:0] addr, wdata, mem_rdata;
    logic        done, err, busy, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;

    lsu_ctrl #(.TIMEOUT_CYC(T)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .byte_acc  (byte_acc),
        .addr      (addr),
        .wdata     (wdata),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          busy, mreq, mwe, done, err;
        logic [31:0] maddr, mwdata, rdata;
    } exp_t;

    exp_t        expq[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] held_rdata = '0;
    bit          held_err   = 1'b0;

    // results observed during the most recent do_access
    int          last_done_idx;
    int          last_rd_cycles;
    bit          last_we_seen;
    logic [31:0] last_addr, last_wdata, last_rdata;
    logic        last_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push(input bit b, mr, mw, d, e, input logic [31:0] ma, mwd, rd);
        exp_t x;
        x.busy = b; x.mreq = mr; x.mwe = mw; x.done = d; x.err = e;
        x.maddr = ma; x.mwdata = mwd; x.rdata = rd;
        expq.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison against the queued model expectations.
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (expq.size() > 0) begin
            e  = expq.pop_front();
            ok = (busy === e.busy) && (mem_req === e.mreq) && (mem_we === e.mwe) &&
                 (done === e.done) && (err === e.err) && (rdata === e.rdata) &&
                 (!e.mreq || mem_addr === e.maddr) && (!e.mwe || mem_wdata === e.mwdata);
            n_checks++;
            if (ok) n_pass++;
            else $display("FAIL cycle t=%0t got busy=%b req=%b we=%b done=%b err=%b addr=%h wd=%h rd=%h expected busy=%b req=%b we=%b done=%b err=%b addr=%h wd=%h rd=%h",
                          $time, busy, mem_req, mem_we, done, err, mem_addr, mem_wdata, rdata,
                          e.busy, e.mreq, e.mwe, e.done, e.err, e.maddr, e.mwdata, e.rdata);
        end
    end

    task automatic sample(input int idx);
        if (done === 1'b1 && last_done_idx < 0) last_done_idx = idx;
        if (mem_req === 1'b1 && mem_we === 1'b0) last_rd_cycles++;
        if (mem_req === 1'b1) last_addr = mem_addr;
        if (mem_we === 1'b1) begin
            last_we_seen = 1'b1;
            last_wdata   = mem_wdata;
        end
    endtask

    task automatic idle_cycles(input int n, input bit noise);
        repeat (n) begin
            tick();
            req = 1'b0; mem_ack = noise;
            push(0, 0, 0, 0, held_err, '0, '0, held_rdata);
        end
    endtask

    // One access: plan the phases from the rules, drive, queue expectations.
    // rd_dly / wr_dly = cycles of waiting before ack in that phase (>= T: never).
    task automatic do_access(input bit w, b, input logic [31:0] a, wd, rw,
                             input int rd_dly, wr_dly, input bit noise);
        logic [31:0] al     = {a[31:2], 2'b00};
        int          sh     = 8 * int'(a[1:0]);
        bit          has_rd = !w || b;
        bit          rd_ok  = rd_dly < T;
        bit          has_wr = w && (!b || rd_ok);
        bit          exp_err = (has_rd && !rd_ok) || (has_wr && wr_dly >= T);
        logic [31:0] exp_wd  = b ? ((rw & ~(32'hFF << sh)) | ({24'b0, wd[7:0]} << sh)) : wd;
        logic [31:0] exp_rd  = (exp_err || w) ? 32'h0 : (b ? ((rw >> sh) & 32'hFF) : rw);
        int          idx = 0;
        last_done_idx = -1; last_rd_cycles = 0; last_we_seen = 1'b0;
        last_addr = 'x; last_wdata = 'x;
        // accept cycle (controller idle, request presented)
        tick();
        req = 1'b1; we = w; byte_acc = b; addr = a; wdata = wd; mem_rdata = rw; mem_ack = noise;
        push(0, 0, 0, 0, held_err, '0, '0, held_rdata);
        sample(idx); idx++;
        if (has_rd) begin
            for (int k = 0; k < T; k++) begin
                tick();
                mem_ack = (k == rd_dly);
                push(1, 1, 0, 0, held_err, al, '0, held_rdata);
                sample(idx); idx++;
                if (k == rd_dly) break;
            end
        end
        if (has_wr) begin
            for (int k = 0; k < T; k++) begin
                tick();
                mem_ack = (k == wr_dly);
                push(1, 1, 1, 0, held_err, al, exp_wd, held_rdata);
                sample(idx); idx++;
                if (k == wr_dly) break;
            end
        end
        tick();
        mem_ack = noise;
        held_rdata = exp_rd; held_err = exp_err;
        push(1, 0, 0, 1, exp_err, '0, '0, exp_rd);
        sample(idx);
        last_rdata = rdata; last_err = err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; req = 1'b0; we = 1'b0; byte_acc = 1'b0;
        addr = '0; wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        #1;
        check("rst_done",  32'(done),    32'h0);
        check("rst_err",   32'(err),     32'h0);
        check("rst_busy",  32'(busy),    32'h0);
        check("rst_mreq",  32'(mem_req), 32'h0);
        check("rst_mwe",   32'(mem_we),  32'h0);
        check("rst_rdata", rdata,        32'h0);
        check("rst_maddr", mem_addr,     32'h0);
        check("rst_mwd",   mem_wdata,    32'h0);
        tick(); tick();
        reset = 1'b1;
        idle_cycles(2, 1'b0);

        // byte load, lane 2, zero wait
        do_access(0, 1, 32'h0000_1002, 32'h0, 32'hAABB_CCDD, 0, 0, 0);
        check("bload_rdata", last_rdata, 32'h0000_00BB);
        check("bload_err",   32'(last_err), 32'h0);
        check("bload_lat",   32'(last_done_idx), 32'd2);
        idle_cycles(1, 0);

        // word load, misaligned address ignored
        do_access(0, 0, 32'h0000_1003, 32'h0, 32'h1234_5678, 0, 0, 0);
        check("wload_addr",  last_addr,  32'h0000_1000);
        check("wload_rdata", last_rdata, 32'h1234_5678);
        idle_cycles(1, 0);

        // byte store read-modify-write, lane 1
        do_access(1, 1, 32'h0000_2001, 32'h0000_00EE, 32'h1122_3344, 0, 0, 0);
        check("bstore_wdata", last_wdata, 32'h1122_EE44);
        check("bstore_lat",   32'(last_done_idx), 32'd3);
        idle_cycles(1, 0);

        // word store, zero wait
        do_access(1, 0, 32'h0000_3006, 32'hCAFE_F00D, 32'h0, 0, 0, 0);
        check("wstore_wdata", last_wdata, 32'hCAFE_F00D);
        check("wstore_lat",   32'(last_done_idx), 32'd2);
        idle_cycles(1, 0);

        // byte loads on the other lanes with wait states
        do_access(0, 1, 32'h0000_5000, 32'h0, 32'h8899_AABB, 3, 0, 0);
        do_access(0, 1, 32'h0000_5001, 32'h0, 32'h8899_AABB, 1, 0, 0);
        do_access(0, 1, 32'h0000_5003, 32'h0, 32'h8899_AABB, 2, 0, 0);
        check("bload_lane3", last_rdata, 32'h0000_0088);
        idle_cycles(1, 0);

        // byte stores with long waits in both phases (counter must clear per phase)
        do_access(1, 1, 32'h0000_6000, 32'h0000_0011, 32'hFFFF_FFFF, 10, 10, 0);
        do_access(1, 1, 32'h0000_6002, 32'h0000_0022, 32'hFFFF_FFFF, 10, 10, 0);
        do_access(1, 1, 32'h0000_6003, 32'h0000_0033, 32'h0000_0000, 12, 12, 0);
        check("bstore_lane3", last_wdata, 32'h3300_0000);
        check("bstore_long_err", 32'(last_err), 32'h0);
        idle_cycles(1, 0);

        // ack on the timeout cycle completes normally
        do_access(0, 0, 32'h0000_7000, 32'h0, 32'h0BAD_BEEF, T - 1, 0, 0);
        check("ack_at_limit_err",   32'(last_err), 32'h0);
        check("ack_at_limit_rdata", last_rdata,    32'h0BAD_BEEF);
        idle_cycles(1, 0);

        // load timeout
        do_access(0, 0, 32'h0000_8000, 32'h0, 32'h1111_2222, 100, 0, 0);
        check("tmo_load_err",   32'(last_err),       32'h1);
        check("tmo_load_rdata", last_rdata,          32'h0);
        check("tmo_load_waits", 32'(last_rd_cycles), 32'd16);
        idle_cycles(1, 0);

        // byte store whose read phase times out: no write phase
        do_access(1, 1, 32'h0000_8001, 32'h0000_0077, 32'h1111_2222, 100, 0, 0);
        check("tmo_bstore_we",  32'(last_we_seen), 32'h0);
        check("tmo_bstore_err", 32'(last_err),     32'h1);
        idle_cycles(1, 0);

        // word store whose write phase times out
        do_access(1, 0, 32'h0000_9000, 32'h5A5A_5A5A, 32'h0, 0, 100, 0);
        check("tmo_wstore_err", 32'(last_err), 32'h1);
        idle_cycles(1, 0);

        // back-to-back with req held through done, ack noise in IDLE/DONE
        do_access(0, 0, 32'h0000_A000, 32'h0, 32'hDEAD_0001, 0, 0, 1);
        do_access(0, 1, 32'h0000_A001, 32'h0, 32'hDEAD_C0DE, 0, 0, 1);
        check("b2b_rdata", last_rdata, 32'h0000_00C0);
        idle_cycles(3, 1'b1);

        // reset during a write-phase wait
        tick();
        req = 1'b1; we = 1'b1; byte_acc = 1'b0; addr = 32'h0000_4000; wdata = 32'h55; mem_ack = 1'b0;
        push(0, 0, 0, 0, held_err, '0, '0, held_rdata);
        repeat (3) begin
            tick();
            push(1, 1, 1, 0, held_err, 32'h0000_4000, 32'h55, held_rdata);
        end
        tick();
        #2;
        reset = 1'b0; req = 1'b0;
        #1;
        check("rstmid_mreq", 32'(mem_req), 32'h0);
        check("rstmid_busy", 32'(busy),    32'h0);
        check("rstmid_done", 32'(done),    32'h0);
        tick();
        check("rstmid_done2", 32'(done), 32'h0);
        tick();
        reset = 1'b1;
        held_rdata = '0; held_err = 1'b0;
        idle_cycles(4, 1'b0);

        // recovery after reset
        do_access(0, 1, 32'h0000_B000, 32'h0, 32'h0102_0304, 0, 0, 0);
        check("post_rst_rdata", last_rdata, 32'h0000_0004);
        idle_cycles(2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: maximum wait cycles for mem_ack before a memory phase aborts.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req  input  1  CPU access request; held with its operands until done.
REQ-005 we  input  1  1 = store, 0 = load.
REQ-006 byte  input  1  1 = byte access (LDRB/STRB), 0 = word access.
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  store data; byte stores use wdata[7:0].
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 rdata  output  32  load result, zero-extended for byte loads; valid while done is high.
REQ-011 err  output  1  timeout flag; valid while done is high.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 mem_req / mem_we  output  1 / 1  memory port request and write enable.
REQ-014 mem_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-015 mem_wdata  output  32  word written to memory.
REQ-016 mem_rdata  input  32  memory read word; valid when mem_ack is high.
REQ-017 mem_ack  input  1  memory completion for the current mem_req.

Function
REQ-018 The FSM SHALL have four states: IDLE, RD, WR and DONE.
REQ-019 IDLE SHALL sample req; on req=1 it SHALL latch we, byte, addr and wdata, then go to RD for a load or byte store, or to WR for a word store.
REQ-020 RD SHALL drive mem_req=1 and mem_we=0; on mem_ack it SHALL latch mem_rdata.
REQ-021 From RD on mem_ack, a load SHALL go to DONE and a byte store SHALL go to WR.
REQ-022 A byte load SHALL return lane addr[1:0] (00->[7:0], 01->[15:8], 10->[23:16], 11->[31:24]), zero-extended; a word load SHALL return the full word.
REQ-023 WR SHALL drive mem_req=1 and mem_we=1, and on mem_ack SHALL go to DONE.
REQ-024 For a word store mem_wdata SHALL equal wdata; for a byte store it SHALL equal the latched read word with lane addr[1:0] replaced by wdata[7:0] (read-modify-write).
REQ-025 Word accesses SHALL ignore addr[1:0] (no alignment fault).
REQ-026 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-027 rdata and err SHALL hold their values until the next DONE.
REQ-028 The requester SHALL drop req on the edge where done is high; req is ignored outside IDLE.
REQ-029 A wait counter SHALL clear on entry to RD or WR and increment on each cycle without mem_ack.
REQ-030 When the wait counter reaches TIMEOUT_CYC, the controller SHALL go to DONE with err=1 and rdata=0, and SHALL issue no write phase; this applies to a byte store whose read phase times out.
REQ-031 mem_ack SHALL be ignored in IDLE and DONE.
REQ-032 Latency, with req accepted at edge N: a zero-wait load or word store SHALL assert done in cycle N+2; a zero-wait byte store SHALL assert done in cycle N+3.
REQ-033 An access that receives mem_ack on the timeout cycle SHALL complete normally (ack has priority).

Reset
REQ-034 While reset=0 the controller SHALL be in state IDLE, with done, err, busy, mem_req and mem_we = 0; rdata, mem_addr and mem_wdata = 0; wait counter = 0.
REQ-035 Reset asserted mid-access SHALL drop mem_req asynchronously, abandon the access and produce no done.

Structure
REQ-036 Package lsu_pkg SHALL hold the state encoding, TIMEOUT_CYC default and lane-index constants.
REQ-037 Sub-module lane_unit (combinational) SHALL perform byte extraction and byte merge, selected by addr[1:0].

Verification
REQ-038 Byte load: addr=0x1002, mem_rdata=0xAABBCCDD, ack on first cycle -> rdata=0x000000BB, done in cycle N+2, err=0.
REQ-039 Word load: addr=0x1003, mem_rdata=0x12345678 -> mem_addr=0x1000, rdata=0x12345678.
REQ-040 Byte store: addr=0x2001, wdata=0x000000EE, read word 0x11223344 -> write phase mem_wdata=0x1122EE44, done in cycle N+3.
REQ-041 Timeout: load with mem_ack held low, TIMEOUT_CYC=16 -> done with err=1 and rdata=0 after 16 RD wait cycles; the byte-store variant issues no mem_we=1.
REQ-042 Reset mid-access: reset=0 during a 3-cycle WR wait -> mem_req=0 immediately, IDLE after release, no done pulse.
REQ-043 Back-to-back: req held high through done -> new access accepted in the IDLE cycle after DONE; mem_ack pulsed in IDLE -> ignored.
